frame_read_buffer: RTL and testbench

- Upstream feeder for the video timing/data stage: it answers that stage's per-frame read_req, fetches one frame of pixels from the frame-store memory port in bursts, and buffers them in an internal single-clock FIFO.
- It supplies read_data one cycle after each read_en.
- Memory side uses the burst-request interface of the frame-store controller: req/len/addr out; data_valid/data/finish in.

---
 rtl/frame_read_buffer.sv | 232 +++++++++++++++++++++++
 tb/tb_frame_read_buffer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_read_buffer.sv
// Frame read buffer: fetches one frame per read_req from the frame store in bursts into a FIFO.
// Optional FRB_UNDERFLOW_CNT_EN adds underflow_cnt/underflow_last per-frame underflow counters.
module frame_read_buffer #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    ADDR_WIDTH  = 24,
  parameter int                    FIFO_DEPTH  = 512,
  parameter int                    BURST_LEN   = 64,
  parameter int                    FRAME_WORDS = 921600,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = {ADDR_WIDTH{1'b0}}
) (
  input  logic                          video_clk,
  input  logic                          rst,
  input  logic                          read_req,
  output logic                          read_req_ack,
  input  logic                          read_en,
  output logic [DATA_WIDTH-1:0]         read_data,
  output logic                          rd_burst_req,
  output logic [9:0]                    rd_burst_len,
  output logic [ADDR_WIDTH-1:0]         rd_burst_addr,
  input  logic                          rd_burst_data_valid,
  input  logic [DATA_WIDTH-1:0]         rd_burst_data,
  input  logic                          rd_burst_finish,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow
`ifdef FRB_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]                   underflow_cnt,
  output logic [15:0]                   underflow_last
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int REM_W = $clog2(FRAME_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ACK         = 3'd1,
    FILL        = 3'd2,
    BURST       = 3'd3,
    DRAIN_ABORT = 3'd4
  } state_t;

  state_t                  state_r;
  logic [DATA_WIDTH-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [LVL_W-1:0]        level_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [REM_W-1:0]        remaining_r;
  logic [DATA_WIDTH-1:0]   read_data_r;
  logic                    underflow_r;
  logic                    ack_r;
  logic                    burst_req_r;
  logic [9:0]              burst_len_r;
  logic [ADDR_WIDTH-1:0]   burst_addr_r;

  logic                    push_s;
  logic                    pop_s;
  logic                    uf_s;
  logic [31:0]             rem_ext_s;
  logic [9:0]              len_s;
  logic [LVL_W-1:0]        free_s;
  logic                    can_issue_s;

`ifdef FRB_UNDERFLOW_CNT_EN
  logic [15:0]             uf_cnt_r;
  logic [15:0]             uf_last_r;
`endif

  // FIFO push/pop qualification and next-burst credit check
  always_comb begin
    push_s      = 1'b0;
    pop_s       = 1'b0;
    uf_s        = 1'b0;
    rem_ext_s   = 32'(remaining_r);
    len_s       = 10'(BURST_LEN);
    free_s      = LVL_W'(FIFO_DEPTH) - level_r;
    can_issue_s = 1'b0;
    if (((state_r == BURST) || (state_r == DRAIN_ABORT)) && rd_burst_data_valid &&
        (level_r != LVL_W'(FIFO_DEPTH))) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    // Pops during ACK are discarded because the FIFO is being flushed
    if (read_en && (state_r != ACK)) begin
      if (level_r != {LVL_W{1'b0}}) begin
        pop_s = 1'b1;
      end else begin
        uf_s = 1'b1;
      end
    end else begin
      pop_s = 1'b0;
    end
    if (rem_ext_s < 32'(BURST_LEN)) begin
      len_s = rem_ext_s[9:0];
    end else begin
      len_s = 10'(BURST_LEN);
    end
    if ((remaining_r != {REM_W{1'b0}}) && (32'(free_s) >= 32'(len_s))) begin
      can_issue_s = 1'b1;
    end else begin
      can_issue_s = 1'b0;
    end
  end

  // FIFO storage write port
  always_ff @(posedge video_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= rd_burst_data;
    end
  end

  // Frame/burst FSM, FIFO pointers and all registered outputs
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      level_r      <= {LVL_W{1'b0}};
      addr_r       <= BASE_ADDR;
      remaining_r  <= REM_W'(FRAME_WORDS);
      read_data_r  <= {DATA_WIDTH{1'b0}};
      underflow_r  <= 1'b0;
      ack_r        <= 1'b0;
      burst_req_r  <= 1'b0;
      burst_len_r  <= 10'd0;
      burst_addr_r <= {ADDR_WIDTH{1'b0}};
`ifdef FRB_UNDERFLOW_CNT_EN
      uf_cnt_r     <= 16'd0;
      uf_last_r    <= 16'd0;
`endif
    end else begin
      if (state_r == ACK) begin
        wr_ptr_r    <= {PTR_W{1'b0}};
        rd_ptr_r    <= {PTR_W{1'b0}};
        level_r     <= {LVL_W{1'b0}};
        underflow_r <= 1'b0;
`ifdef FRB_UNDERFLOW_CNT_EN
        uf_last_r   <= uf_cnt_r;
        uf_cnt_r    <= 16'd0;
`endif
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
        case ({push_s, pop_s})
          2'b10:   level_r <= level_r + LVL_W'(1'b1);
          2'b01:   level_r <= level_r - LVL_W'(1'b1);
          default: level_r <= level_r;
        endcase
        if (uf_s) underflow_r <= 1'b1;
`ifdef FRB_UNDERFLOW_CNT_EN
        if (uf_s && (uf_cnt_r != 16'hFFFF)) uf_cnt_r <= uf_cnt_r + 16'd1;
`endif
      end

      if (pop_s) begin
        read_data_r <= mem_r[rd_ptr_r];
      end else if (uf_s) begin
        read_data_r <= {DATA_WIDTH{1'b0}};
      end

      case (state_r)
        IDLE: begin
          if (read_req) begin
            ack_r   <= 1'b1;
            state_r <= ACK;
          end
        end
        ACK: begin
          ack_r       <= 1'b0;
          addr_r      <= BASE_ADDR;
          remaining_r <= REM_W'(FRAME_WORDS);
          state_r     <= FILL;
        end
        FILL: begin
          if (read_req) begin
            ack_r   <= 1'b1;
            state_r <= ACK;
          end else if (can_issue_s) begin
            burst_req_r  <= 1'b1;
            burst_addr_r <= addr_r;
            burst_len_r  <= len_s;
            state_r      <= BURST;
          end
        end
        BURST: begin
          if (rd_burst_finish) begin
            burst_req_r <= 1'b0;
            addr_r      <= addr_r + ADDR_WIDTH'(burst_len_r);
            remaining_r <= remaining_r - REM_W'(burst_len_r);
            if (read_req) begin
              ack_r   <= 1'b1;
              state_r <= ACK;
            end else begin
              state_r <= FILL;
            end
          end else if (read_req) begin
            state_r <= DRAIN_ABORT;
          end
        end
        // Let the outstanding burst complete, then restart the frame
        DRAIN_ABORT: begin
          if (rd_burst_finish) begin
            burst_req_r <= 1'b0;
            ack_r       <= 1'b1;
            state_r     <= ACK;
          end
        end
        default: begin
          ack_r       <= 1'b0;
          burst_req_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign read_req_ack  = ack_r;
  assign read_data     = read_data_r;
  assign rd_burst_req  = burst_req_r;
  assign rd_burst_len  = burst_len_r;
  assign rd_burst_addr = burst_addr_r;
  assign fifo_level    = level_r;
  assign underflow     = underflow_r;
`ifdef FRB_UNDERFLOW_CNT_EN
  assign underflow_cnt  = uf_cnt_r;
  assign underflow_last = uf_last_r;
`endif

endmodule

// File: tb/tb_frame_read_buffer.sv
// Directed bench for frame_read_buffer with a small frame (200 words, 128-entry FIFO, base 0x100).
module tb_frame_read_buffer;

  localparam int          DW    = 16;
  localparam int          AW    = 24;
  localparam int          DEPTH = 128;
  localparam int          BL    = 64;
  localparam int          FW    = 200;
  localparam logic [23:0] BASE  = 24'h000100;
  localparam int          LW    = $clog2(DEPTH) + 1;

  logic          video_clk;
  logic          rst;
  logic          read_req;
  logic          read_req_ack;
  logic          read_en;
  logic [DW-1:0] read_data;
  logic          rd_burst_req;
  logic [9:0]    rd_burst_len;
  logic [AW-1:0] rd_burst_addr;
  logic          rd_burst_data_valid;
  logic [DW-1:0] rd_burst_data;
  logic          rd_burst_finish;
  logic [LW-1:0] fifo_level;
  logic          underflow;
`ifdef FRB_UNDERFLOW_CNT_EN
  logic [15:0]   underflow_cnt;
  logic [15:0]   underflow_last;
`endif

  frame_read_buffer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH),
    .BURST_LEN(BL), .FRAME_WORDS(FW), .BASE_ADDR(BASE)
  ) dut (
    .video_clk(video_clk), .rst(rst),
    .read_req(read_req), .read_req_ack(read_req_ack),
    .read_en(read_en), .read_data(read_data),
    .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
    .rd_burst_finish(rd_burst_finish),
    .fifo_level(fifo_level), .underflow(underflow)
`ifdef FRB_UNDERFLOW_CNT_EN
    , .underflow_cnt(underflow_cnt), .underflow_last(underflow_last)
`endif
  );

  initial video_clk = 1'b0;
  always #5 video_clk = ~video_clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [23:0] addr;
    logic [9:0]  len;
  } burst_vec_t;

  typedef struct {
    logic          en;
    logic [DW-1:0] exp_data;
    logic          exp_uf;
    logic [LW-1:0] exp_level;
  } pop_vec_t;

  burst_vec_t  exp_bursts [4];
  pop_vec_t    uf_vecs [8];

  logic [23:0] log_addr [16];
  logic [9:0]  log_len  [16];
  int          log_n = 0;

  logic [23:0] m_addr;
  logic [9:0]  m_len;
  bit          m_abort;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-store model: word at address A holds A[15:0]
  initial begin
    rd_burst_data_valid = 1'b0;
    rd_burst_data       = 16'h0000;
    rd_burst_finish     = 1'b0;
    forever begin
      @(posedge video_clk);
      if (!rst && rd_burst_req) begin
        m_addr  = rd_burst_addr;
        m_len   = rd_burst_len;
        m_abort = 1'b0;
        if (log_n < 16) begin
          log_addr[log_n] = m_addr;
          log_len[log_n]  = m_len;
        end
        log_n++;
        @(negedge video_clk);
        for (int i = 0; i < int'(m_len); i++) begin
          @(negedge video_clk);
          if (rst) begin
            m_abort             = 1'b1;
            rd_burst_data_valid = 1'b0;
            break;
          end
          rd_burst_data_valid = 1'b1;
          rd_burst_data       = 16'(m_addr + 24'(i));
        end
        @(negedge video_clk);
        rd_burst_data_valid = 1'b0;
        rd_burst_finish     = !m_abort;
        @(negedge video_clk);
        rd_burst_finish     = 1'b0;
      end
    end
  end

  task automatic do_req(input string name);
    int lat;
    lat = 0;
    read_req = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge video_clk);
      if (read_req_ack) begin
        lat = i;
        break;
      end
    end
    chk($sformatf("%s ack latency", name), 32'(lat), 32'd1);
    read_req = 1'b0;
    @(negedge video_clk);
    chk($sformatf("%s ack one cycle", name), {31'd0, read_req_ack}, 32'd0);
  endtask

  task automatic wait_level(input int val, input int max_cyc, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge video_clk);
      if (int'(fifo_level) == val) begin
        found = 1'b1;
        break;
      end
    end
    chk($sformatf("%s reach level %0d", name, val), {31'd0, found}, 32'd1);
  endtask

  task automatic pop_words(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      @(negedge video_clk);
      if (i > 0) chk($sformatf("pop word %0d", start + i - 1), 32'(read_data), 32'(16'(BASE + 24'(start + i - 1))));
      read_en = 1'b1;
    end
    @(negedge video_clk);
    read_en = 1'b0;
    chk($sformatf("pop word %0d", start + n - 1), 32'(read_data), 32'(16'(BASE + 24'(start + n - 1))));
  endtask

  initial begin
    bit seen;
    bit got;
    bit fin_now;
    bit on_time;
    int beats;

    exp_bursts[0] = '{addr: 24'h000100, len: 10'd64};
    exp_bursts[1] = '{addr: 24'h000140, len: 10'd64};
    exp_bursts[2] = '{addr: 24'h000180, len: 10'd64};
    exp_bursts[3] = '{addr: 24'h0001C0, len: 10'd8};
    // After the frame drains: last word was 0x01C7, then five underflowing pops
    uf_vecs[0] = '{en: 1'b0, exp_data: 16'h01C7, exp_uf: 1'b0, exp_level: 8'd0};
    uf_vecs[1] = '{en: 1'b1, exp_data: 16'h0000, exp_uf: 1'b1, exp_level: 8'd0};
    uf_vecs[2] = '{en: 1'b0, exp_data: 16'h0000, exp_uf: 1'b1, exp_level: 8'd0};
    uf_vecs[3] = '{en: 1'b1, exp_data: 16'h0000, exp_uf: 1'b1, exp_level: 8'd0};
    uf_vecs[4] = '{en: 1'b1, exp_data: 16'h0000, exp_uf: 1'b1, exp_level: 8'd0};
    uf_vecs[5] = '{en: 1'b1, exp_data: 16'h0000, exp_uf: 1'b1, exp_level: 8'd0};
    uf_vecs[6] = '{en: 1'b1, exp_data: 16'h0000, exp_uf: 1'b1, exp_level: 8'd0};
    uf_vecs[7] = '{en: 1'b0, exp_data: 16'h0000, exp_uf: 1'b1, exp_level: 8'd0};

    rst      = 1'b1;
    read_req = 1'b0;
    read_en  = 1'b0;
    repeat (3) @(negedge video_clk);
    chk("reset ack",        {31'd0, read_req_ack}, 32'd0);
    chk("reset burst_req",  {31'd0, rd_burst_req}, 32'd0);
    chk("reset level",      32'(fifo_level), 32'd0);
    chk("reset underflow",  {31'd0, underflow}, 32'd0);
    chk("reset read_data",  32'(read_data), 32'd0);
    chk("reset burst_len",  32'(rd_burst_len), 32'd0);
    chk("reset burst_addr", 32'(rd_burst_addr), 32'd0);
    rst = 1'b0;

    // Reset in the middle of a burst
    do_req("frameA");
    wait_level(37, 300, "frameA");
    rst = 1'b1;
    #1;
    chk("midreset burst_req", {31'd0, rd_burst_req}, 32'd0);
    chk("midreset ack",       {31'd0, read_req_ack}, 32'd0);
    chk("midreset level",     32'(fifo_level), 32'd0);
    chk("midreset underflow", {31'd0, underflow}, 32'd0);
    repeat (4) @(negedge video_clk);
    rst   = 1'b0;
    log_n = 0;
    seen  = 1'b0;
    repeat (30) begin
      @(negedge video_clk);
      if (rd_burst_req) seen = 1'b1;
    end
    chk("no burst after reset", {31'd0, seen}, 32'd0);
    chk("no burst logged after reset", 32'(log_n), 32'd0);

    // Fill without pops: credit limits to two bursts
    do_req("frameB");
    wait_level(128, 600, "frameB");
    repeat (20) @(negedge video_clk);
    chk("fill level", 32'(fifo_level), 32'd128);
    chk("fill burst count", 32'(log_n), 32'd2);
    chk("fill burst_req idle", {31'd0, rd_burst_req}, 32'd0);

    // 63 pops leave 63 free slots: still no third burst
    pop_words(63, 0);
    repeat (20) @(negedge video_clk);
    chk("credit hold burst count", 32'(log_n), 32'd2);
    chk("read_data hold", 32'(read_data), 32'h0000013E);
    chk("credit hold level", 32'(fifo_level), 32'd65);
    pop_words(1, 63);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge video_clk);
      if (log_n == 3) begin
        got = 1'b1;
        break;
      end
    end
    chk("third burst after 64 pops", {31'd0, got}, 32'd1);
    pop_words(136, 64);
    repeat (20) @(negedge video_clk);
    chk("frame burst count", 32'(log_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("burst %0d addr", i), 32'(log_addr[i]), 32'(exp_bursts[i].addr));
      chk($sformatf("burst %0d len", i),  32'(log_len[i]),  32'(exp_bursts[i].len));
    end
    chk("frame underflow", {31'd0, underflow}, 32'd0);
    chk("frame drained level", 32'(fifo_level), 32'd0);
    chk("frame done burst_req", {31'd0, rd_burst_req}, 32'd0);

    // Underflow vectors on the empty FIFO
    for (int i = 0; i < 8; i++) begin
      @(negedge video_clk);
      read_en = uf_vecs[i].en;
      @(negedge video_clk);
      chk($sformatf("uf vec %0d data", i),  32'(read_data),      32'(uf_vecs[i].exp_data));
      chk($sformatf("uf vec %0d flag", i),  {31'd0, underflow},  {31'd0, uf_vecs[i].exp_uf});
      chk($sformatf("uf vec %0d level", i), 32'(fifo_level),     32'(uf_vecs[i].exp_level));
    end
    read_en = 1'b0;
`ifdef FRB_UNDERFLOW_CNT_EN
    chk("underflow_cnt", 32'(underflow_cnt), 32'd5);
`endif

    // New frame clears underflow; its first burst is aborted at the 10th beat
    do_req("frameC");
    chk("frameC underflow cleared", {31'd0, underflow}, 32'd0);
`ifdef FRB_UNDERFLOW_CNT_EN
    chk("underflow_last", 32'(underflow_last), 32'd5);
    chk("underflow_cnt cleared", 32'(underflow_cnt), 32'd0);
`endif
    beats = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge video_clk);
      if (rd_burst_data_valid) beats++;
      if (beats == 9) break;
    end
    chk("abort 9 beats seen", 32'(beats), 32'd9);
    @(negedge video_clk);
    read_req = 1'b1;
    got      = 1'b0;
    on_time  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge video_clk);
      fin_now = rd_burst_finish;
      @(negedge video_clk);
      if (read_req_ack) begin
        got     = 1'b1;
        on_time = fin_now;
        break;
      end
    end
    chk("abort ack seen", {31'd0, got}, 32'd1);
    chk("abort ack at finish+1", {31'd0, on_time}, 32'd1);
    read_req = 1'b0;
    log_n    = 0;
    @(negedge video_clk);
    chk("abort ack one cycle", {31'd0, read_req_ack}, 32'd0);
    chk("abort flushed level", 32'(fifo_level), 32'd0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge video_clk);
      if (log_n >= 1) begin
        got = 1'b1;
        break;
      end
    end
    chk("restart burst issued", {31'd0, got}, 32'd1);
    chk("restart burst addr", 32'(log_addr[0]), 32'(BASE));
    chk("restart burst len",  32'(log_len[0]),  32'd64);
    wait_level(64, 200, "restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
